// File: rtl/flash_responder_pkg.sv
// Shared constants for the flash responder: command bytes, mode encoding,
// status register bit positions and the manufacturer ID.
package flash_responder_pkg;

    // Command bytes (low byte of the data bus)
    localparam logic [7:0] CMD_READ_ARRAY    = 8'hFF;
    localparam logic [7:0] CMD_READ_STATUS   = 8'h70;
    localparam logic [7:0] CMD_READ_ID       = 8'h90;
    localparam logic [7:0] CMD_CLEAR_STATUS  = 8'h50;
    localparam logic [7:0] CMD_PROGRAM       = 8'h40;
    localparam logic [7:0] CMD_PROGRAM_ALT   = 8'h10;
    localparam logic [7:0] CMD_ERASE         = 8'h20;
    localparam logic [7:0] CMD_ERASE_CONFIRM = 8'hD0;

    typedef enum logic [2:0] {
        MODE_READ_ARRAY  = 3'd0,
        MODE_READ_STATUS = 3'd1,
        MODE_READ_ID     = 3'd2,
        MODE_PROG_SETUP  = 3'd3,
        MODE_ERASE_SETUP = 3'd4,
        MODE_PROG_BUSY   = 3'd5,
        MODE_ERASE_BUSY  = 3'd6
    } mode_e;

    // Status register bit indices
    localparam int SR_READY     = 7;
    localparam int SR_ERASE_ERR = 5;
    localparam int SR_PROG_ERR  = 4;
    localparam int SR_VPP_ERR   = 3;

    localparam logic [7:0]  SR_RESET = 8'h80;
    localparam logic [15:0] MFR_ID   = 16'h0089;

    function automatic logic is_busy(input mode_e m);
        return (m == MODE_PROG_BUSY) || (m == MODE_ERASE_BUSY);
    endfunction

endpackage

// File: rtl/flash_responder_sync.sv
// Two-stage synchroniser for the flash bus plus write-strobe detection.
// The write strobe fires on the rising edge of synced we_n while synced
// ce_n is low; the address/data reported with it are the second-stage
// values from the cycle before the edge, i.e. while we_n was still low.
module flash_responder_sync
    import flash_responder_pkg::*;
#(
    parameter int adr_width = 24
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [adr_width-1:0] adr_i,
    input  logic [15:0]          d_i,
    input  logic                 ce_n_i,
    input  logic                 oe_n_i,
    input  logic                 we_n_i,
    input  logic                 rst_n_i,
    output logic                 ce_n_o,
    output logic                 oe_n_o,
    output logic                 we_n_o,
    output logic                 rst_n_o,
    output logic [adr_width-1:0] adr_o,
    output logic                 wr_stb_o,
    output logic [adr_width-1:0] wr_adr_o,
    output logic [15:0]          wr_data_o
);

    // control bit order: {rst_n, ce_n, oe_n, we_n}; idle level is all ones
    logic [3:0]           ctl_s1_q, ctl_s2_q;
    logic [adr_width-1:0] adr_s1_q, adr_s2_q, wr_adr_q;
    logic [15:0]          d_s1_q, d_s2_q, wr_data_q;
    logic                 we_n_prev_q;

    // Two register stages on every bus input, plus a one-cycle history of
    // the second stage for the write edge detector.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ctl_s1_q    <= 4'b1111;
            ctl_s2_q    <= 4'b1111;
            adr_s1_q    <= '0;
            adr_s2_q    <= '0;
            d_s1_q      <= '0;
            d_s2_q      <= '0;
            wr_adr_q    <= '0;
            wr_data_q   <= '0;
            we_n_prev_q <= 1'b1;
        end else begin
            ctl_s1_q    <= {rst_n_i, ce_n_i, oe_n_i, we_n_i};
            ctl_s2_q    <= ctl_s1_q;
            adr_s1_q    <= adr_i;
            adr_s2_q    <= adr_s1_q;
            d_s1_q      <= d_i;
            d_s2_q      <= d_s1_q;
            wr_adr_q    <= adr_s2_q;
            wr_data_q   <= d_s2_q;
            we_n_prev_q <= ctl_s2_q[0];
        end
    end

    assign rst_n_o   = ctl_s2_q[3];
    assign ce_n_o    = ctl_s2_q[2];
    assign oe_n_o    = ctl_s2_q[1];
    assign we_n_o    = ctl_s2_q[0];
    assign adr_o     = adr_s2_q;
    assign wr_adr_o  = wr_adr_q;
    assign wr_data_o = wr_data_q;
    assign wr_stb_o  = ctl_s2_q[0] & ~we_n_prev_q & ~ctl_s2_q[2];

endmodule

// File: rtl/flash_responder.sv
// Cycle-based stand-in for a 16-bit Intel/CFI NOR flash on the fjmem bus.
//
// mode              | meaning
// ------------------+-----------------------------------------------------
// MODE_READ_ARRAY   | reads return array words
// MODE_READ_STATUS  | reads return {8'h00, SR}
// MODE_READ_ID      | reads return manufacturer/device ID by block offset
// MODE_PROG_SETUP   | next write programs one word
// MODE_ERASE_SETUP  | next write must be D0 to start a block erase
// MODE_PROG_BUSY    | program in progress, writes ignored, sts low
// MODE_ERASE_BUSY   | block clear then settle time, writes ignored, sts low
//
// The array holds inverted data so that an all-zero power-up state (FPGA
// block RAM without an init file, zero-initialised simulation) reads back
// as erased flash (16'hFFFF). Programming therefore ORs in ~data and
// erasing writes zero.
module flash_responder
    import flash_responder_pkg::*;
#(
    parameter int          adr_width     = 24,
    parameter int          mem_adr_width = 12,
    parameter int          blk_adr_width = 8,
    parameter int          prog_cycles   = 16,
    parameter int          erase_extra   = 32,
    parameter logic [15:0] dev_id        = 16'h8960
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [adr_width-1:0] flash_adr,
    input  logic [15:0]          flash_d_i,
    output logic [15:0]          flash_d_o,
    output logic                 flash_d_oe,
    input  logic                 flash_oe_n,
    input  logic                 flash_we_n,
    input  logic                 flash_ce_n,
    input  logic                 flash_rst_n,
    output logic                 flash_sts
);

    localparam int MEM_DEPTH    = 1 << mem_adr_width;
    localparam int ERASE_CYCLES = (1 << blk_adr_width) + erase_extra;
    localparam int BUSY_MAX     = (prog_cycles > ERASE_CYCLES) ? prog_cycles : ERASE_CYCLES;
    localparam int CNT_W        = $clog2(BUSY_MAX + 1);

    localparam logic [mem_adr_width-1:0] BLK_MASK = mem_adr_width'((1 << blk_adr_width) - 1);
    localparam logic [blk_adr_width-1:0] OFS_MFR  = '0;
    localparam logic [blk_adr_width-1:0] OFS_DEV  = blk_adr_width'(1);

    logic                 ce_n_s, oe_n_s, we_n_s, rst_n_s;
    logic [adr_width-1:0] adr_s, wr_adr_s;
    logic [15:0]          wr_data_s;
    logic                 wr_stb;
    logic                 fsm_rst;

    flash_responder_sync #(
        .adr_width (adr_width)
    ) u_sync (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .adr_i     (flash_adr),
        .d_i       (flash_d_i),
        .ce_n_i    (flash_ce_n),
        .oe_n_i    (flash_oe_n),
        .we_n_i    (flash_we_n),
        .rst_n_i   (flash_rst_n),
        .ce_n_o    (ce_n_s),
        .oe_n_o    (oe_n_s),
        .we_n_o    (we_n_s),
        .rst_n_o   (rst_n_s),
        .adr_o     (adr_s),
        .wr_stb_o  (wr_stb),
        .wr_adr_o  (wr_adr_s),
        .wr_data_o (wr_data_s)
    );

    assign fsm_rst = sys_rst | ~rst_n_s;

    logic [mem_adr_width-1:0] rd_adr, prog_adr;
    logic                     unused_adr_hi;

    assign rd_adr        = adr_s[mem_adr_width-1:0];
    assign prog_adr      = wr_adr_s[mem_adr_width-1:0];
    assign unused_adr_hi = ^{adr_s[adr_width-1:mem_adr_width], wr_adr_s[adr_width-1:mem_adr_width]};

    mode_e                    mode_q;
    logic [7:0]               sr_q;
    logic [CNT_W-1:0]         busy_cnt_q;
    logic [blk_adr_width-1:0] blk_cnt_q;
    logic                     clearing_q;
    logic [mem_adr_width-1:0] erase_base_q;
    logic                     sts_q;

    logic [15:0]              mem_q [MEM_DEPTH];
    logic                     mem_we;
    logic [mem_adr_width-1:0] mem_wadr;
    logic [15:0]              mem_wdata;
    logic [7:0]               cmd;

    assign cmd = wr_data_s[7:0];

    // Array write port: one programmed word, or one cleared word per erase cycle.
    always_comb begin
        mem_we    = 1'b0;
        mem_wadr  = prog_adr;
        mem_wdata = '0;
        if (!fsm_rst) begin
            if (mode_q == MODE_PROG_SETUP && wr_stb) begin
                mem_we    = 1'b1;
                mem_wadr  = prog_adr;
                mem_wdata = mem_q[prog_adr] | ~wr_data_s;
            end else if (mode_q == MODE_ERASE_BUSY && clearing_q) begin
                mem_we    = 1'b1;
                mem_wadr  = erase_base_q | mem_adr_width'(blk_cnt_q);
                mem_wdata = '0;
            end
        end
    end

    // Word array; deliberately outside any reset so contents survive resets.
    always_ff @(posedge sys_clk) begin
        if (mem_we) begin
            mem_q[mem_wadr] <= mem_wdata;
        end
    end

    logic [15:0] rd_word, rd_data;
    assign rd_word = ~mem_q[rd_adr];

    // Select what a read returns for the current mode and synced address.
    always_comb begin
        rd_data = {8'h00, sr_q};
        if (!is_busy(mode_q)) begin
            case (mode_q)
                MODE_READ_ARRAY: rd_data = rd_word;
                MODE_READ_ID: begin
                    if (adr_s[blk_adr_width-1:0] == OFS_MFR) begin
                        rd_data = MFR_ID;
                    end else if (adr_s[blk_adr_width-1:0] == OFS_DEV) begin
                        rd_data = dev_id;
                    end else begin
                        rd_data = '0;
                    end
                end
                default: rd_data = {8'h00, sr_q};
            endcase
        end
    end

    // Registered read data and bus-drive enable; a concurrent write keeps the bus released.
    always_ff @(posedge sys_clk) begin
        if (fsm_rst) begin
            flash_d_o  <= '0;
            flash_d_oe <= 1'b0;
        end else begin
            flash_d_o  <= rd_data;
            flash_d_oe <= ~ce_n_s & ~oe_n_s & we_n_s;
        end
    end

    // Command decoder, program/erase sequencing and busy timing.
    always_ff @(posedge sys_clk) begin
        if (fsm_rst) begin
            mode_q       <= MODE_READ_ARRAY;
            sr_q         <= SR_RESET;
            busy_cnt_q   <= '0;
            blk_cnt_q    <= '0;
            clearing_q   <= 1'b0;
            erase_base_q <= '0;
            sts_q        <= 1'b1;
        end else begin
            case (mode_q)
                MODE_READ_ARRAY, MODE_READ_STATUS, MODE_READ_ID: begin
                    if (wr_stb) begin
                        case (cmd)
                            CMD_READ_ARRAY:   mode_q <= MODE_READ_ARRAY;
                            CMD_READ_STATUS:  mode_q <= MODE_READ_STATUS;
                            CMD_READ_ID:      mode_q <= MODE_READ_ID;
                            CMD_CLEAR_STATUS: begin
                                sr_q[SR_ERASE_ERR] <= 1'b0;
                                sr_q[SR_PROG_ERR]  <= 1'b0;
                                sr_q[SR_VPP_ERR]   <= 1'b0;
                            end
                            CMD_PROGRAM, CMD_PROGRAM_ALT: mode_q <= MODE_PROG_SETUP;
                            CMD_ERASE:        mode_q <= MODE_ERASE_SETUP;
                            default:          mode_q <= MODE_READ_ARRAY;
                        endcase
                    end
                end
                MODE_PROG_SETUP: begin
                    if (wr_stb) begin
                        sr_q[SR_READY] <= 1'b0;
                        busy_cnt_q     <= CNT_W'(prog_cycles - 1);
                        sts_q          <= 1'b0;
                        mode_q         <= MODE_PROG_BUSY;
                    end
                end
                MODE_ERASE_SETUP: begin
                    if (wr_stb) begin
                        if (cmd == CMD_ERASE_CONFIRM) begin
                            sr_q[SR_READY] <= 1'b0;
                            busy_cnt_q     <= CNT_W'(ERASE_CYCLES - 1);
                            blk_cnt_q      <= '0;
                            clearing_q     <= 1'b1;
                            erase_base_q   <= prog_adr & ~BLK_MASK;
                            sts_q          <= 1'b0;
                            mode_q         <= MODE_ERASE_BUSY;
                        end else begin
                            sr_q[SR_ERASE_ERR] <= 1'b1;
                            sr_q[SR_PROG_ERR]  <= 1'b1;
                            mode_q             <= MODE_READ_STATUS;
                        end
                    end
                end
                MODE_PROG_BUSY, MODE_ERASE_BUSY: begin
                    if (clearing_q) begin
                        blk_cnt_q <= blk_cnt_q + 1'b1;
                        if (&blk_cnt_q) begin
                            clearing_q <= 1'b0;
                        end
                    end
                    if (busy_cnt_q == '0) begin
                        sr_q[SR_READY] <= 1'b1;
                        sts_q          <= 1'b1;
                        mode_q         <= MODE_READ_STATUS;
                    end else begin
                        busy_cnt_q <= busy_cnt_q - 1'b1;
                    end
                end
                default: mode_q <= MODE_READ_ARRAY;
            endcase
        end
    end

    assign flash_sts = sts_q;

endmodule

// File: tb/tb_flash_responder.sv
// Directed bench for flash_responder: read path latency, program, erase,
// command sequence error, clear status, device reset mid-erase and read ID.
module tb_flash_responder;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [23:0] flash_adr;
    logic [15:0] flash_d_i;
    logic [15:0] flash_d_o;
    logic        flash_d_oe;
    logic        flash_oe_n;
    logic        flash_we_n;
    logic        flash_ce_n;
    logic        flash_rst_n;
    logic        flash_sts;

    int n_pass  = 0;
    int n_total = 0;

    flash_responder dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .flash_adr   (flash_adr),
        .flash_d_i   (flash_d_i),
        .flash_d_o   (flash_d_o),
        .flash_d_oe  (flash_d_oe),
        .flash_oe_n  (flash_oe_n),
        .flash_we_n  (flash_we_n),
        .flash_ce_n  (flash_ce_n),
        .flash_rst_n (flash_rst_n),
        .flash_sts   (flash_sts)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Write cycle; returns how many sampled cycles flash_sts was low afterwards.
    task automatic bus_write(input logic [23:0] a, input logic [15:0] d, output int lows);
        flash_adr  = a;
        flash_d_i  = d;
        flash_we_n = 1'b0;
        repeat (3) tick();
        flash_we_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (flash_sts === 1'b0) lows++;
            else if (i >= 8) break;
        end
    endtask

    task automatic bus_read(input logic [23:0] a, output logic [15:0] d, output logic oe);
        flash_adr  = a;
        flash_oe_n = 1'b0;
        repeat (3) tick();
        d  = flash_d_o;
        oe = flash_d_oe;
        flash_oe_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic        oe;
        sys_rst = 1'b1; flash_rst_n = 1'b1; flash_ce_n = 1'b1;
        flash_oe_n = 1'b1; flash_we_n = 1'b1; flash_adr = '0; flash_d_i = '0;
        repeat (4) tick();
        n_total++;
        if ({flash_d_oe, flash_d_o, flash_sts} !== {1'b0, 16'h0000, 1'b1}) begin
            $display("FAIL reset_outputs: got oe=%b d=%h sts=%b want oe=0 d=0000 sts=1", flash_d_oe, flash_d_o, flash_sts);
        end else n_pass++;
        sys_rst = 1'b0; flash_ce_n = 1'b0;
        repeat (3) tick();

        flash_adr = 24'h000010; flash_oe_n = 1'b0;
        repeat (2) tick();
        n_total++;
        if (flash_d_oe !== 1'b0) $display("FAIL oe_early: got %b want 0 two cycles after oe_n fall", flash_d_oe);
        else n_pass++;
        tick();
        d = flash_d_o; oe = flash_d_oe;
        flash_oe_n = 1'b1;
        repeat (3) tick();
        n_total++;
        if ({oe, d} !== {1'b1, 16'hFFFF}) $display("FAIL read_erased: got oe=%b d=%h want oe=1 d=ffff", oe, d);
        else n_pass++;
        n_total++;
        if (flash_sts !== 1'b1) $display("FAIL sts_idle: got %b want 1", flash_sts);
        else n_pass++;

        // oe_n and we_n both low: the write wins, bus stays released
        flash_d_i = 16'h00FF; flash_oe_n = 1'b0; flash_we_n = 1'b0;
        repeat (4) tick();
        n_total++;
        if (flash_d_oe !== 1'b0) $display("FAIL write_wins: got oe=%b want 0", flash_d_oe);
        else n_pass++;
        flash_oe_n = 1'b1; flash_we_n = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_program();
        logic [15:0] d;
        logic        oe;
        int          lows;
        bus_write(24'h20, 16'h0040, lows);
        bus_write(24'h20, 16'h1234, lows);
        n_total++;
        if (lows !== 16) $display("FAIL prog_busy_len: got %0d want 16", lows);
        else n_pass++;
        bus_read(24'h20, d, oe);
        n_total++;
        if (d !== 16'h0080) $display("FAIL prog_status: got %h want 0080", d);
        else n_pass++;
        bus_write(24'h0, 16'h00FF, lows);
        bus_read(24'h20, d, oe);
        n_total++;
        if (d !== 16'h1234) $display("FAIL prog_read: got %h want 1234", d);
        else n_pass++;
    endtask

    task automatic test_program_and();
        logic [15:0] d;
        logic        oe;
        int          lows;
        bus_write(24'h20, 16'h0010, lows);
        bus_write(24'h20, 16'h00FF, lows);
        bus_write(24'h0, 16'h00FF, lows);
        bus_read(24'h20, d, oe);
        n_total++;
        if (d !== 16'h0034) $display("FAIL prog_and: got %h want 0034", d);
        else n_pass++;
    endtask

    task automatic test_erase();
        logic [15:0] d;
        logic        oe;
        int          lows;
        bus_write(24'h0FF, 16'h0040, lows);
        bus_write(24'h0FF, 16'hA5A5, lows);
        bus_write(24'h150, 16'h0040, lows);
        bus_write(24'h150, 16'h1111, lows);
        bus_write(24'h200, 16'h0040, lows);
        bus_write(24'h200, 16'h5A5A, lows);
        bus_write(24'h0, 16'h00FF, lows);
        bus_read(24'h150, d, oe);
        n_total++;
        if (d !== 16'h1111) $display("FAIL erase_pre: got %h want 1111", d);
        else n_pass++;
        bus_write(24'h123, 16'h0020, lows);
        bus_write(24'h123, 16'h00D0, lows);
        n_total++;
        if (lows !== 288) $display("FAIL erase_busy_len: got %0d want 288", lows);
        else n_pass++;
        bus_read(24'h0, d, oe);
        n_total++;
        if (d !== 16'h0080) $display("FAIL erase_status: got %h want 0080", d);
        else n_pass++;
        bus_write(24'h0, 16'h00FF, lows);
        bus_read(24'h100, d, oe);
        n_total++;
        if (d !== 16'hFFFF) $display("FAIL erase_first: got %h want ffff", d);
        else n_pass++;
        bus_read(24'h150, d, oe);
        n_total++;
        if (d !== 16'hFFFF) $display("FAIL erase_mid: got %h want ffff", d);
        else n_pass++;
        bus_read(24'h1FF, d, oe);
        n_total++;
        if (d !== 16'hFFFF) $display("FAIL erase_last: got %h want ffff", d);
        else n_pass++;
        bus_read(24'h0FF, d, oe);
        n_total++;
        if (d !== 16'hA5A5) $display("FAIL erase_below: got %h want a5a5", d);
        else n_pass++;
        bus_read(24'h200, d, oe);
        n_total++;
        if (d !== 16'h5A5A) $display("FAIL erase_above: got %h want 5a5a", d);
        else n_pass++;
    endtask

    task automatic test_seq_error();
        logic [15:0] d;
        logic        oe;
        int          lows;
        bus_write(24'h0, 16'h0020, lows);
        bus_write(24'h0, 16'h0055, lows);
        n_total++;
        if (lows !== 0) $display("FAIL seqerr_busy: got %0d low cycles want 0", lows);
        else n_pass++;
        bus_read(24'h0, d, oe);
        n_total++;
        if (d !== 16'h00B0) $display("FAIL seqerr_status: got %h want 00b0", d);
        else n_pass++;
        bus_write(24'h0, 16'h0050, lows);
        bus_read(24'h0, d, oe);
        n_total++;
        if (d !== 16'h0080) $display("FAIL clear_status: got %h want 0080", d);
        else n_pass++;
        // unknown command falls back to read array
        bus_write(24'h0, 16'h0033, lows);
        bus_read(24'h200, d, oe);
        n_total++;
        if (d !== 16'h5A5A) $display("FAIL unknown_cmd: got %h want 5a5a", d);
        else n_pass++;
    endtask

    task automatic test_reset_mid_erase();
        logic [15:0] d;
        logic        oe;
        int          lows;
        bus_write(24'h300, 16'h0040, lows);
        bus_write(24'h300, 16'h1234, lows);
        bus_write(24'h305, 16'h0040, lows);
        bus_write(24'h305, 16'h0F0F, lows);
        bus_write(24'h3F0, 16'h0040, lows);
        bus_write(24'h3F0, 16'h4321, lows);
        bus_write(24'h300, 16'h0020, lows);
        flash_adr = 24'h300; flash_d_i = 16'h00D0; flash_we_n = 1'b0;
        repeat (3) tick();
        flash_we_n = 1'b1;
        repeat (4) tick();
        n_total++;
        if (flash_sts !== 1'b0) $display("FAIL erase_started: got sts=%b want 0", flash_sts);
        else n_pass++;
        bus_read(24'h300, d, oe);
        n_total++;
        if (d !== 16'h0000) $display("FAIL busy_read: got %h want 0000", d);
        else n_pass++;
        flash_rst_n = 1'b0;
        repeat (4) tick();
        n_total++;
        if (flash_sts !== 1'b1) $display("FAIL rst_sts: got %b want 1", flash_sts);
        else n_pass++;
        flash_rst_n = 1'b1;
        repeat (4) tick();
        bus_read(24'h300, d, oe);
        n_total++;
        if (d !== 16'hFFFF) $display("FAIL rst_erased0: got %h want ffff", d);
        else n_pass++;
        bus_read(24'h305, d, oe);
        n_total++;
        if (d !== 16'hFFFF) $display("FAIL rst_erased5: got %h want ffff", d);
        else n_pass++;
        bus_read(24'h3F0, d, oe);
        n_total++;
        if (d !== 16'h4321) $display("FAIL rst_kept: got %h want 4321", d);
        else n_pass++;

        bus_write(24'h0, 16'h0090, lows);
        bus_read(24'h000, d, oe);
        n_total++;
        if (d !== 16'h0089) $display("FAIL id_mfr: got %h want 0089", d);
        else n_pass++;
        bus_read(24'h001, d, oe);
        n_total++;
        if (d !== 16'h8960) $display("FAIL id_dev: got %h want 8960", d);
        else n_pass++;
        bus_read(24'h002, d, oe);
        n_total++;
        if (d !== 16'h0000) $display("FAIL id_other: got %h want 0000", d);
        else n_pass++;
        bus_read(24'h101, d, oe);
        n_total++;
        if (d !== 16'h8960) $display("FAIL id_blk_ofs: got %h want 8960", d);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_program();
        test_program_and();
        test_erase();
        test_seq_error();
        test_reset_mid_erase();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_total);
        $fatal(1);
    end

endmodule
